sim_argmax_search: RTL

Downstream consumer of the similarity kernel mapper. Once the mapper has written a set of cosine similarities into the similarity DPRAM, this block scans a contiguous window of IEEE-754 single-precision entries. It reports the index and value of the maximum, which is the classification result for the query hypervector. It owns the read port of the similarity DPRAM and never writes it.

---
 rtl/sim_search_pkg.sv | 20 ++
 rtl/sim_fp_compare.sv | 21 ++
 rtl/sim_argmax_search.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sim_search_pkg.sv
// Shared types and IEEE-754 single-precision helpers for the similarity argmax search.
// Shared by the comparator and the search top; see SIM_ARGMAX_TOPTWO_EN in sim_argmax_search.
package sim_search_pkg;

    typedef logic [1:0] SimArgmax_State_t;

    localparam SimArgmax_State_t S_IDLE  = 2'd0;
    localparam SimArgmax_State_t S_READ  = 2'd1;
    localparam SimArgmax_State_t S_DRAIN = 2'd2;
    localparam SimArgmax_State_t S_DONE  = 2'd3;

    localparam logic [31:0] FP_EXP_MASK = 32'h7F80_0000;
    localparam logic [31:0] FP_MAN_MASK = 32'h007F_FFFF;

    // Maps a float onto an unsigned key whose integer order matches numeric order.
    function automatic logic [31:0] fp_order_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

endpackage

// File: rtl/sim_fp_compare.sv
// Combinational IEEE-754 single compare: a > b under total order, with +0 == -0, plus NaN flags.
module sim_fp_compare
    import sim_search_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_gt_b,
    output logic        a_is_nan,
    output logic        b_is_nan
);

    logic both_zero;

    assign a_is_nan  = ((a & FP_EXP_MASK) == FP_EXP_MASK) && ((a & FP_MAN_MASK) != 32'd0);
    assign b_is_nan  = ((b & FP_EXP_MASK) == FP_EXP_MASK) && ((b & FP_MAN_MASK) != 32'd0);

    // The raw keys order -0 below +0, so equal-magnitude zeros are forced to compare equal.
    assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    assign a_gt_b    = !both_zero && (fp_order_key(a) > fp_order_key(b));

endmodule

// File: rtl/sim_argmax_search.sv
// Scans a window of the similarity DPRAM and reports index/value of the maximum entry.
// Define SIM_ARGMAX_TOPTWO_EN to also track and report the runner-up.
module sim_argmax_search
    import sim_search_pkg::*;
#(
    parameter int SIM_DATA_WIDTH    = 32,
    parameter int SIM_ADDRESS_WIDTH = 5,
    parameter int RAM_READ_LATENCY  = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         valid,
    input  logic [SIM_ADDRESS_WIDTH-1:0] base_addr,
    input  logic [SIM_ADDRESS_WIDTH:0]   count,
    output logic [SIM_ADDRESS_WIDTH-1:0] s_address,
    input  logic [SIM_DATA_WIDTH-1:0]    s_data_rd,
    output logic                         done,
    output logic                         found,
    output logic [SIM_ADDRESS_WIDTH-1:0] best_index,
    output logic [SIM_DATA_WIDTH-1:0]    best_value
`ifdef SIM_ARGMAX_TOPTWO_EN
    ,
    output logic [SIM_ADDRESS_WIDTH-1:0] second_index,
    output logic [SIM_DATA_WIDTH-1:0]    second_value
`endif
);

    SimArgmax_State_t             state_reg;
    logic [SIM_ADDRESS_WIDTH:0]   remaining_reg;
    logic [SIM_ADDRESS_WIDTH-1:0] s_address_reg;
    logic                         done_reg;
    logic                         found_reg;
    logic [SIM_ADDRESS_WIDTH-1:0] best_index_reg;
    logic [SIM_DATA_WIDTH-1:0]    best_value_reg;

    logic                         run_have_reg;
    logic [SIM_ADDRESS_WIDTH-1:0] run_idx_reg;
    logic [SIM_DATA_WIDTH-1:0]    run_val_reg;

    logic [RAM_READ_LATENCY-1:0]  tag_valid_reg;
    logic [SIM_ADDRESS_WIDTH-1:0] tag_addr_reg [RAM_READ_LATENCY];
    logic                         pipe_head_busy;

    logic                         tag_out_valid;
    logic [SIM_ADDRESS_WIDTH-1:0] tag_out_addr;
    logic                         gt_best;
    logic                         new_is_nan;
    logic                         best_nan_unused;
    logic                         take_best;
    logic                         start;

    assign start         = (state_reg == S_IDLE) && valid;
    assign tag_out_valid = tag_valid_reg[RAM_READ_LATENCY-1];
    assign tag_out_addr  = tag_addr_reg[RAM_READ_LATENCY-1];

    // Tag pipe mirrors the RAM latency so each returning word arrives with its address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_reg <= '0;
            for (int j = 0; j < RAM_READ_LATENCY; j++) begin
                tag_addr_reg[j] <= '0;
            end
        end else begin
            tag_valid_reg[0] <= (state_reg == S_READ);
            tag_addr_reg[0]  <= s_address_reg;
            for (int j = 1; j < RAM_READ_LATENCY; j++) begin
                tag_valid_reg[j] <= tag_valid_reg[j-1];
                tag_addr_reg[j]  <= tag_addr_reg[j-1];
            end
        end
    end

    // The last stage is being compared this cycle, so only earlier stages keep DRAIN waiting.
    generate
        if (RAM_READ_LATENCY > 1) begin : g_head_busy
            assign pipe_head_busy = |tag_valid_reg[RAM_READ_LATENCY-2:0];
        end else begin : g_no_head
            assign pipe_head_busy = 1'b0;
        end
    endgenerate

    sim_fp_compare u_cmp_best (
        .a        (s_data_rd),
        .b        (run_val_reg),
        .a_gt_b   (gt_best),
        .a_is_nan (new_is_nan),
        .b_is_nan (best_nan_unused)
    );

    assign take_best = tag_out_valid && !new_is_nan && (!run_have_reg || gt_best);

`ifdef SIM_ARGMAX_TOPTWO_EN
    logic                         sec_have_reg;
    logic [SIM_ADDRESS_WIDTH-1:0] sec_idx_reg;
    logic [SIM_DATA_WIDTH-1:0]    sec_val_reg;
    logic [SIM_ADDRESS_WIDTH-1:0] second_index_reg;
    logic [SIM_DATA_WIDTH-1:0]    second_value_reg;
    logic                         gt_sec;
    logic                         sec_a_nan_unused;
    logic                         sec_b_nan_unused;
    logic                         take_sec;

    sim_fp_compare u_cmp_second (
        .a        (s_data_rd),
        .b        (sec_val_reg),
        .a_gt_b   (gt_sec),
        .a_is_nan (sec_a_nan_unused),
        .b_is_nan (sec_b_nan_unused)
    );

    assign take_sec = tag_out_valid && !new_is_nan && !take_best && (!sec_have_reg || gt_sec);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_have_reg     <= 1'b0;
            sec_idx_reg      <= '0;
            sec_val_reg      <= '0;
            second_index_reg <= '0;
            second_value_reg <= '0;
        end else begin
            if (start) begin
                sec_have_reg <= 1'b0;
                sec_idx_reg  <= base_addr;
                sec_val_reg  <= '0;
            end else if (take_best && run_have_reg) begin
                sec_have_reg <= 1'b1;
                sec_idx_reg  <= run_idx_reg;
                sec_val_reg  <= run_val_reg;
            end else if (take_sec) begin
                sec_have_reg <= 1'b1;
                sec_idx_reg  <= tag_out_addr;
                sec_val_reg  <= s_data_rd;
            end
            if (state_reg == S_DONE) begin
                second_index_reg <= sec_idx_reg;
                second_value_reg <= sec_val_reg;
            end
        end
    end

    assign second_index = second_index_reg;
    assign second_value = second_value_reg;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            remaining_reg  <= '0;
            s_address_reg  <= '0;
            done_reg       <= 1'b1;
            found_reg      <= 1'b0;
            best_index_reg <= '0;
            best_value_reg <= '0;
            run_have_reg   <= 1'b0;
            run_idx_reg    <= '0;
            run_val_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (valid) begin
                        done_reg <= 1'b0;
                        if (count == '0) begin
                            state_reg <= S_DONE;
                        end else begin
                            state_reg     <= S_READ;
                            s_address_reg <= base_addr;
                            remaining_reg <= count - 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (remaining_reg == '0) begin
                        state_reg <= S_DRAIN;
                    end else begin
                        s_address_reg <= s_address_reg + 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!pipe_head_busy) begin
                        state_reg <= S_DONE;
                    end
                end
                default: begin
                    done_reg       <= 1'b1;
                    found_reg      <= run_have_reg;
                    best_index_reg <= run_idx_reg;
                    best_value_reg <= run_val_reg;
                    state_reg      <= S_IDLE;
                end
            endcase

            if (start) begin
                run_have_reg <= 1'b0;
                run_idx_reg  <= base_addr;
                run_val_reg  <= '0;
            end else if (take_best) begin
                run_have_reg <= 1'b1;
                run_idx_reg  <= tag_out_addr;
                run_val_reg  <= s_data_rd;
            end
        end
    end

    assign s_address  = s_address_reg;
    assign done       = done_reg;
    assign found      = found_reg;
    assign best_index = best_index_reg;
    assign best_value = best_value_reg;

endmodule
